// File: rtl/mode_pkg.sv
// Shared types and defaults for the clock-display mode controller.
package mode_pkg;

  typedef enum logic [1:0] {
    S_TIME      = 2'd0,
    S_ALARMSET  = 2'd1,
    S_STOPWATCH = 2'd2
  } mode_t;

  localparam logic [15:0] DEBOUNCE_DEF = 16'd20000;
  localparam logic [5:0]  TIMEOUT_DEF  = 6'd30;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-level debounce and registered press pulse
// for a front-panel push button.
module btn_debounce
  import mode_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic        sync_1;
  logic        btn_s;
  logic        btn_d;
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
      btn_d  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn;
      btn_s  <= sync_1;
      press  <= 1'b0;
      if (btn_s == btn_d) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        // Accept the new level; only a 0->1 acceptance is a press.
        btn_d <= btn_s;
        cnt   <= '0;
        press <= btn_s;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Mode FSM (TIME -> ALARMSET -> STOPWATCH), alarm-set inactivity timeout
// and registered select decode for the display digit muxes.
module mode_sequencer
  import mode_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter logic [5:0]  TIMEOUT_SEC     = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic MODE_BTN,
  input  logic SEC_TICK,
  input  logic SET_ACTIVITY,
  input  logic ALARM_RING,
  output logic ALARMSET_RUN,
  output logic STOPWATCH_RUN,
  output logic MODE_CHG
);

  mode_t      state;
  mode_t      next_state;
  logic       press;
  logic       timeout;
  logic [5:0] tmo_cnt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk   (CLK),
    .rst   (RST),
    .btn   (MODE_BTN),
    .press (press)
  );

  always_comb begin
    timeout = (state == S_ALARMSET) && SEC_TICK && !SET_ACTIVITY &&
              (tmo_cnt == TIMEOUT_SEC - 6'd1);
    next_state = state;
    if (ALARM_RING) begin
      next_state = S_TIME;
    end else begin
      case (state)
        S_TIME:      if (press) next_state = S_ALARMSET;
        S_ALARMSET:  if (press) next_state = S_STOPWATCH;
                     else if (timeout) next_state = S_TIME;
        S_STOPWATCH: if (press) next_state = S_TIME;
        default:     next_state = S_TIME;
      endcase
    end
  end

  // Selects and MODE_CHG are registered from next_state so they move
  // together with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_TIME;
      ALARMSET_RUN  <= 1'b0;
      STOPWATCH_RUN <= 1'b0;
      MODE_CHG      <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      state         <= next_state;
      ALARMSET_RUN  <= (next_state == S_ALARMSET);
      STOPWATCH_RUN <= (next_state == S_STOPWATCH);
      MODE_CHG      <= (next_state != state);
      if (state != S_ALARMSET || next_state != S_ALARMSET || SET_ACTIVITY)
        tmo_cnt <= '0;
      else if (SEC_TICK && tmo_cnt != TIMEOUT_SEC - 6'd1)
        tmo_cnt <= tmo_cnt + 6'd1;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: expected mode changes (cycle and
// selects) are queued at stimulus time and matched on each MODE_CHG pulse.
module tb_mode_sequencer;

  logic CLK = 1'b0;
  logic RST, MODE_BTN, SEC_TICK, SET_ACTIVITY, ALARM_RING;
  logic ALARMSET_RUN, STOPWATCH_RUN, MODE_CHG;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
  } ev_t;

  ev_t sb[$];
  int  cyc     = 0;
  int  n_tests = 0;
  int  n_fail  = 0;

  localparam int LAT = 2 + 4 + 1;

  mode_sequencer #(.DEBOUNCE_CYCLES(16'd4), .TIMEOUT_SEC(6'd3)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .MODE_BTN      (MODE_BTN),
    .SEC_TICK      (SEC_TICK),
    .SET_ACTIVITY  (SET_ACTIVITY),
    .ALARM_RING    (ALARM_RING),
    .ALARMSET_RUN  (ALARMSET_RUN),
    .STOPWATCH_RUN (STOPWATCH_RUN),
    .MODE_CHG      (MODE_CHG)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic [1:0] s);
    ev_t e;
    e.cyc = c;
    e.sel = s;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST && MODE_CHG) begin
      n_tests++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_chg: observed MODE_CHG with sel=%b at cycle %0d, required none",
               {ALARMSET_RUN, STOPWATCH_RUN}, cyc);
      end
      if (sb.size() > 0) begin
        ev_t e;
        e = sb.pop_front();
        check("chg_cycle", cyc, e.cyc);
        check("chg_sel", {30'd0, ALARMSET_RUN, STOPWATCH_RUN}, {30'd0, e.sel});
      end
    end
    if (ALARMSET_RUN && STOPWATCH_RUN) check("sel_exclusive", 2'b11, 2'b00);
  end

  task automatic press_step(input logic [1:0] sel, input bit expect_chg);
    @(negedge CLK);
    MODE_BTN = 1'b1;
    if (expect_chg) push_exp(cyc + LAT, sel);
    repeat (10) @(negedge CLK);
    MODE_BTN = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic tick(input bit act, input bit expect_tmo);
    @(negedge CLK);
    SEC_TICK = 1'b1;
    SET_ACTIVITY = act;
    if (expect_tmo) push_exp(cyc + 1, 2'b00);
    @(negedge CLK);
    SEC_TICK = 1'b0;
    SET_ACTIVITY = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; MODE_BTN = 1'b0; SEC_TICK = 1'b0; SET_ACTIVITY = 1'b0; ALARM_RING = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_alarmset", ALARMSET_RUN, 1'b0);
    check("rst_stopwatch", STOPWATCH_RUN, 1'b0);
    check("rst_mode_chg", MODE_CHG, 1'b0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Full cycle TIME -> ALARMSET -> STOPWATCH -> TIME
    press_step(2'b10, 1'b1);
    check("cycle_as", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b10);
    press_step(2'b01, 1'b1);
    check("cycle_sw", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b01);
    press_step(2'b00, 1'b1);
    check("cycle_time", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b00);

    // Short glitch then a bounce train: no event
    @(negedge CLK); MODE_BTN = 1'b1;
    repeat (3) @(negedge CLK);
    MODE_BTN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      MODE_BTN = ~MODE_BTN;
    end
    repeat (20) @(negedge CLK);
    check("glitch_sel", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b00);

    // Plain timeout after three ticks
    press_step(2'b10, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("tmo_not_yet", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b10);
    tick(1'b0, 1'b1);
    check("tmo_time", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b00);

    // Activity on the second tick restarts the count
    press_step(2'b10, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("act_still_as", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b10);
    tick(1'b0, 1'b1);
    check("act_time", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b00);

    // Press coinciding with the final timeout tick goes to STOPWATCH
    press_step(2'b10, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    @(negedge CLK);
    MODE_BTN = 1'b1;
    push_exp(cyc + LAT, 2'b01);
    repeat (LAT - 1) @(negedge CLK);
    SEC_TICK = 1'b1;
    @(negedge CLK);
    SEC_TICK = 1'b0;
    repeat (3) @(negedge CLK);
    MODE_BTN = 1'b0;
    repeat (8) @(negedge CLK);
    check("coinc_sw", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b01);

    // Ringing alarm forces TIME and masks presses
    @(negedge CLK);
    ALARM_RING = 1'b1;
    push_exp(cyc + 1, 2'b00);
    @(negedge CLK);
    check("ring_time", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b00);
    press_step(2'b00, 1'b0);
    check("ring_masked", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b00);
    @(negedge CLK);
    ALARM_RING = 1'b0;
    press_step(2'b10, 1'b1);
    check("post_ring_as", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b10);
    press_step(2'b01, 1'b1);

    // Asynchronous reset in STOPWATCH and mid-debounce, button held through it
    @(negedge CLK);
    MODE_BTN = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("arst_alarmset", ALARMSET_RUN, 1'b0);
    check("arst_stopwatch", STOPWATCH_RUN, 1'b0);
    check("arst_mode_chg", MODE_CHG, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    push_exp(cyc + LAT, 2'b10);
    repeat (12) @(negedge CLK);
    MODE_BTN = 1'b0;
    repeat (10) @(negedge CLK);
    check("held_press_as", {ALARMSET_RUN, STOPWATCH_RUN}, 2'b10);

    repeat (20) @(negedge CLK);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
